// File: rtl/rs_enc_frame_sched.sv
// Round-robin scheduler that gathers K-symbol frames from NCH requesters and bursts
// each frame into one shared RS(16,8) encoder, tagging the codeword with its channel.
module rs_enc_frame_sched #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned K       = 8,
   parameter int unsigned TIMEOUT = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [NCH-1:0]         ch_valid,
   input  logic [8*NCH-1:0]       ch_data,
   output logic [NCH-1:0]         ch_ready,
   output logic                   enc_din_val,
   output logic                   enc_din_sop,
   output logic [7:0]             enc_din,
   input  logic                   enc_dout_eop,
   output logic [$clog2(NCH)-1:0] cur_ch,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   err_timeout
);
   localparam int unsigned CHW = $clog2(NCH);
   localparam int unsigned CW  = $clog2(K+1);
   localparam int unsigned TW  = $clog2(TIMEOUT+1);
   localparam int unsigned BW  = (K > 1) ? $clog2(K) : 1;

   localparam logic [CW-1:0]  K_LAST  = CW'(K-1);
   localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT-1);
   localparam logic [CHW-1:0] CH_LAST = CHW'(NCH-1);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
   state_t state_q, state_d;

   logic [CHW-1:0] rr_q, scan_idx, grant_ch;
   logic           grant_ok, xfer;
   logic [CW-1:0]  wcnt_q, scnt_q;
   logic [TW-1:0]  tcnt_q;
   logic [7:0]     frame_buf [K];
   logic [7:0]     ch_sym [NCH];

   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) ch_sym[i] = ch_data[8*i +: 8];
   end

   // First requester at or after rr_q, wrapping modulo NCH.
   always_comb begin
      grant_ok = 1'b0;
      grant_ch = '0;
      scan_idx = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         scan_idx = CHW'((32'(rr_q) + i) % NCH);
         if (!grant_ok && ch_valid[scan_idx]) begin
            grant_ok = 1'b1;
            grant_ch = scan_idx;
         end
      end
   end

   assign xfer = (state_q == LOAD) && ch_valid[cur_ch];

   always_comb begin
      state_d  = state_q;
      ch_ready = '0;
      case (state_q)
         IDLE: if (en && grant_ok) state_d = LOAD;
         LOAD: begin
            ch_ready[cur_ch] = 1'b1;
            if (xfer && wcnt_q == K_LAST) state_d = SEND;
         end
         SEND: if (scnt_q == K_LAST) state_d = WAIT;
         WAIT: if (enc_dout_eop || tcnt_q == T_LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q        <= '0;
         cur_ch      <= '0;
         wcnt_q      <= '0;
         scnt_q      <= '0;
         tcnt_q      <= '0;
         enc_din_val <= 1'b0;
         enc_din_sop <= 1'b0;
         enc_din     <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         enc_din_val <= (state_q == SEND);
         enc_din_sop <= (state_q == SEND) && (scnt_q == '0);
         enc_din     <= (state_q == SEND) ? frame_buf[scnt_q[BW-1:0]] : '0;
         busy        <= (state_d != IDLE);
         // eop beats a simultaneous timeout expiry
         frame_done  <= (state_q == WAIT) && enc_dout_eop;
         err_timeout <= (state_q == WAIT) && !enc_dout_eop && (tcnt_q == T_LAST);
         case (state_q)
            IDLE: begin
               wcnt_q <= '0;
               scnt_q <= '0;
               tcnt_q <= '0;
               if (en && grant_ok) begin
                  cur_ch <= grant_ch;
                  rr_q   <= (grant_ch == CH_LAST) ? '0 : grant_ch + 1'b1;
               end
            end
            LOAD:    if (xfer) wcnt_q <= wcnt_q + 1'b1;
            SEND:    scnt_q <= scnt_q + 1'b1;
            WAIT:    tcnt_q <= tcnt_q + 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (xfer) frame_buf[wcnt_q[BW-1:0]] <= ch_sym[cur_ch];
   end
endmodule

// File: tb/tb_rs_enc_frame_sched.sv
// Scoreboard bench for rs_enc_frame_sched: directed frames, encoder eop model,
// expected symbols/pulses queued at issue time and checked by an output monitor.
module tb_rs_enc_frame_sched;
   localparam int NCH = 4, K = 8, TIMEOUT = 32, EOP_DLY = 8;
   localparam logic [1:0] KD_SYM = 2'd0, KD_DONE = 2'd1, KD_TMO = 2'd2;

   logic             clk, rst_n, en;
   logic [NCH-1:0]   ch_valid, ch_ready;
   logic [8*NCH-1:0] ch_data;
   logic             enc_din_val, enc_din_sop, enc_dout_eop;
   logic [7:0]       enc_din;
   logic [1:0]       cur_ch;
   logic             busy, frame_done, err_timeout;

   int          n_checks = 0, n_fail = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  src_mem [NCH][64];
   logic [5:0]  src_rd [NCH];
   logic [5:0]  src_wr [NCH];
   logic [NCH-1:0] gap_mode, hs;
   logic        eop_en;

   rs_enc_frame_sched #(.NCH(NCH), .K(K), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
      .enc_din_val(enc_din_val), .enc_din_sop(enc_din_sop), .enc_din(enc_din),
      .enc_dout_eop(enc_dout_eop), .cur_ch(cur_ch), .busy(busy),
      .frame_done(frame_done), .err_timeout(err_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] pack(input logic [1:0] kind, input logic [2:0] ch,
                                        input logic sop, input logic [7:0] d);
      return {18'd0, kind, ch, sop, d};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input int ch, input logic [7:0] d0, input logic tmo);
      for (int j = 0; j < K; j++)
         exp_q.push_back(pack(KD_SYM, 3'(ch), (j == 0), d0 + 8'(j)));
      exp_q.push_back(pack(tmo ? KD_TMO : KD_DONE, 3'(ch), 1'b0, 8'h00));
   endtask

   task automatic load_src(input int ch, input logic [7:0] d0);
      for (int j = 0; j < K; j++) begin
         src_mem[ch][src_wr[ch]] = d0 + 8'(j);
         src_wr[ch] = src_wr[ch] + 6'd1;
      end
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      int c;
      c = 0;
      do begin step(); c++; end while (c < max_cyc && !(exp_q.size() == 0 && !busy));
      n_checks++;
      if (!(exp_q.size() == 0 && !busy)) begin
         n_fail++;
         $display("FAIL %s: not idle after %0d cycles, pending=%0d busy=%0b",
                  name, c, exp_q.size(), busy);
      end
   endtask

   // Channel sources: each pops its queue on handshake; gap_mode idles one cycle after each transfer.
   initial begin
      ch_valid = '0;
      ch_data  = '0;
      hs       = '0;
      for (int i = 0; i < NCH; i++) begin
         src_rd[i] = '0;
         src_wr[i] = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NCH; i++) begin
            if (hs[i]) src_rd[i] = src_rd[i] + 6'd1;
            ch_valid[i]      = (src_rd[i] != src_wr[i]) && !(gap_mode[i] && hs[i]);
            ch_data[8*i +: 8] = src_mem[i][src_rd[i]];
            hs[i]            = ch_valid[i] && ch_ready[i];
         end
      end
   end

   // Encoder model: last parity symbol reported EOP_DLY cycles after the data burst ends.
   initial begin
      logic prev_val;
      enc_dout_eop = 1'b0;
      prev_val = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_val && !enc_din_val && eop_en) begin
            repeat (EOP_DLY) @(negedge clk);
            enc_dout_eop = 1'b1;
            @(negedge clk);
            enc_dout_eop = 1'b0;
         end
         prev_val = enc_din_val;
      end
   end

   initial begin
      logic [31:0] e;
      int burst;
      burst = 0;
      forever begin
         @(negedge clk);
         if (enc_din_val) begin
            burst++;
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_sym: got %0h with nothing expected", enc_din);
            end else begin
               e = exp_q.pop_front();
               check("enc_sym", pack(KD_SYM, {1'b0, cur_ch}, enc_din_sop, enc_din), e);
            end
         end else if (burst != 0) begin
            check("burst_len", burst, K);
            burst = 0;
         end
         if (frame_done || err_timeout) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_pulse: done=%0b tmo=%0b", frame_done, err_timeout);
            end else begin
               e = exp_q.pop_front();
               check("end_pulse", pack(err_timeout ? KD_TMO : KD_DONE, {1'b0, cur_ch},
                                       enc_din_sop, enc_din), e);
               check("pulse_excl", {frame_done, err_timeout} != 2'b11, 1);
            end
         end
      end
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
   end

   initial begin
      int c, bound;
      logic [5:0] base;
      rst_n = 1'b0; en = 1'b1; eop_en = 1'b1; gap_mode = '0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_ready", ch_ready, 0);
      check("rst_val", {enc_din_val, enc_din_sop, enc_din}, 0);
      check("rst_cur_ch", cur_ch, 0);
      check("rst_pulses", {frame_done, err_timeout}, 0);
      rst_n = 1'b1;
      step();
      check("idle_busy", busy, 0);

      // all four request at once: grants 0,1,2,3,0
      load_src(0, 8'h10); load_src(1, 8'h20); load_src(2, 8'h30);
      load_src(3, 8'h40); load_src(0, 8'h50);
      push_frame(0, 8'h10, 0); push_frame(1, 8'h20, 0); push_frame(2, 8'h30, 0);
      push_frame(3, 8'h40, 0); push_frame(0, 8'h50, 0);
      wait_idle("rr_order", 400);

      // single channel 2, data 01..08
      load_src(2, 8'h01); push_frame(2, 8'h01, 0);
      wait_idle("ch2_frame", 100);

      // stalling channel 1: 8 transfers over 15 LOAD cycles
      gap_mode = 4'b0010;
      load_src(1, 8'h80); push_frame(1, 8'h80, 0);
      c = 0; bound = 0;
      while (!ch_ready[1] && bound < 50) begin step(); bound++; end
      while (ch_ready[1] && bound < 100) begin c++; step(); bound++; end
      check("load_len", c, 15);
      wait_idle("gap_frame", 100);
      gap_mode = '0;

      // timeout on ch3 frame, ch0 waiting behind it
      eop_en = 1'b0;
      load_src(3, 8'h90); load_src(0, 8'hA0);
      push_frame(3, 8'h90, 1); push_frame(0, 8'hA0, 0);
      bound = 0;
      while (!(enc_din_val && enc_din_sop) && bound < 100) begin step(); bound++; end
      repeat (K-1) step();
      c = 0;
      do begin step(); c++; end while (!err_timeout && c < 100);
      check("tmo_latency", c, TIMEOUT);
      check("tmo_busy", busy, 0);
      eop_en = 1'b1;
      step();
      check("tmo_next_busy", busy, 1);
      check("tmo_next_ch", cur_ch, 0);
      wait_idle("after_tmo", 150);

      // en dropped mid-SEND: frame completes, ch1 held off until en returns
      load_src(0, 8'hB0); push_frame(0, 8'hB0, 0); push_frame(1, 8'hC0, 0);
      step();
      load_src(1, 8'hC0);
      bound = 0;
      while (!(enc_din_val && enc_din_sop) && bound < 100) begin step(); bound++; end
      en = 1'b0;
      bound = 0;
      while (!frame_done && bound < 60) begin step(); bound++; end
      check("en0_done", frame_done, 1);
      for (int i = 0; i < 6; i++) begin
         step();
         check("en0_hold_busy", busy, 0);
         check("en0_hold_ready", ch_ready, 0);
      end
      en = 1'b1;
      step();
      check("en1_busy", busy, 1);
      check("en1_ch", cur_ch, 1);
      check("en1_ready", ch_ready, 4'b0010);
      wait_idle("en_frames", 150);

      // reset after 4 LOAD transfers; afterwards rr_ptr=0 must pick ch0 ahead of ch2
      load_src(0, 8'hD0);
      base = src_rd[0]; bound = 0;
      while (6'(src_rd[0] - base) != 6'd4 && bound < 60) begin step(); bound++; end
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", ch_ready, 0);
      check("mid_rst_val", {enc_din_val, enc_din_sop, enc_din}, 0);
      check("mid_rst_cur_ch", cur_ch, 0);
      src_rd[0] = src_wr[0];
      hs = '0;
      load_src(0, 8'hE0); load_src(2, 8'hF0);
      push_frame(0, 8'hE0, 0); push_frame(2, 8'hF0, 0);
      step(); step();
      rst_n = 1'b1;
      wait_idle("post_rst", 200);

      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
